// File: rtl/ts_pid_filter.sv
// TS packet PID filter: captures 188-byte packets from the sync finder into two
// banks, validates header/PID and forwards only complete accepted packets.
module ts_pid_filter #(
   parameter int unsigned PKT_LEN   = 188,
   parameter bit          DROP_NULL = 1'b1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             DCLK,
   input  logic             RST,
   input  logic [7:0]       DATA_IN,
   input  logic             DVALID_IN,
   input  logic             PSYNC_IN,
   input  logic             SYNC_FOUND_IN,
   input  logic [12:0]      PID_VALUE,
   input  logic             PID_FILTER_EN,
   input  logic             OUT_READY,
   output logic [7:0]       DATA_OUT,
   output logic             DVALID_OUT,
   output logic             PSYNC_OUT,
   output logic [12:0]      PKT_PID,
   output logic [CNT_W-1:0] DROP_CNT,
   output logic [CNT_W-1:0] OVF_CNT
);

   localparam int unsigned IW = $clog2(PKT_LEN + 1);
   localparam int unsigned AW = $clog2(2 * PKT_LEN);
   localparam logic [12:0]    NULL_PID  = 13'h1FFF;
   localparam logic [IW-1:0]  LAST_IDX  = IW'(PKT_LEN - 1);
   localparam logic [IW-1:0]  PKT_LEN_I = IW'(PKT_LEN);

   typedef enum logic [1:0] {W_IDLE, W_FILL, W_SKIP} wstate_t;
   typedef enum logic       {R_IDLE, R_SEND} rstate_t;

   logic [7:0]    mem [2*PKT_LEN];
   logic [7:0]    ram_q;

   wstate_t       wstate;
   rstate_t       rstate;
   logic [1:0]    bank_full;
   logic [12:0]   bank_pid [2];
   logic          wr_ptr;
   logic          rd_ptr;
   logic [IW-1:0] wr_idx;
   logic [IW-1:0] fetch_idx;
   logic [IW-1:0] out_idx;
   logic          tei;
   logic [4:0]    pid_hi;
   logic [7:0]    pid_lo;

   logic          begin_pkt;
   logic          fill_byte;
   logic          commit;
   logic          keep_pkt;
   logic          mem_we;
   logic          ram_re;
   logic          rd_release;
   logic [12:0]   cur_pid;
   logic [IW-1:0] widx;
   logic [IW-1:0] ridx;
   logic [AW-1:0] waddr;
   logic [AW-1:0] raddr;

   function automatic logic [AW-1:0] bank_addr(input logic bank, input logic [IW-1:0] idx);
      return (bank ? AW'(PKT_LEN) : '0) + AW'(idx);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   // begin_pkt covers both a fresh start and a sync byte that cuts a packet short
   always_comb begin
      begin_pkt = DVALID_IN & PSYNC_IN & SYNC_FOUND_IN;
      fill_byte = (wstate == W_FILL) & SYNC_FOUND_IN & DVALID_IN & ~PSYNC_IN;
      commit    = fill_byte & (wr_idx == LAST_IDX);
      cur_pid   = {pid_hi, pid_lo};
      keep_pkt  = !tei
                  && !(DROP_NULL && (cur_pid == NULL_PID))
                  && !(PID_FILTER_EN && (cur_pid != PID_VALUE));
      mem_we    = (begin_pkt & ~bank_full[wr_ptr]) | fill_byte;
      widx      = begin_pkt ? '0 : wr_idx;
      waddr     = bank_addr(wr_ptr, widx);
   end

   always_comb begin
      rd_release = (rstate == R_SEND) & DVALID_OUT & OUT_READY & (out_idx == LAST_IDX);
      ridx       = (rstate == R_IDLE) ? '0 : fetch_idx;
      ram_re     = (rstate == R_IDLE) ? bank_full[rd_ptr]
                                      : ((~DVALID_OUT | OUT_READY) & (fetch_idx < PKT_LEN_I));
      raddr      = bank_addr(rd_ptr, ridx);
   end

   always_ff @(posedge DCLK) begin
      if (mem_we)
         mem[waddr] <= DATA_IN;
      if (ram_re)
         ram_q <= mem[raddr];
   end

   always_ff @(posedge DCLK or negedge RST) begin
      if (!RST) begin
         wstate      <= W_IDLE;
         wr_idx      <= '0;
         wr_ptr      <= 1'b0;
         bank_full   <= '0;
         bank_pid[0] <= '0;
         bank_pid[1] <= '0;
         tei         <= 1'b0;
         pid_hi      <= '0;
         pid_lo      <= '0;
         DROP_CNT    <= '0;
         OVF_CNT     <= '0;
      end else begin
         if (rd_release)
            bank_full[rd_ptr] <= 1'b0;
         if ((wstate != W_IDLE) && !SYNC_FOUND_IN) begin
            if (wstate == W_FILL)
               DROP_CNT <= sat_inc(DROP_CNT);
            wstate <= W_IDLE;
         end else if (begin_pkt) begin
            if (wstate == W_FILL)
               DROP_CNT <= sat_inc(DROP_CNT);
            wr_idx <= IW'(1);
            if (!bank_full[wr_ptr]) begin
               wstate <= W_FILL;
            end else begin
               wstate  <= W_SKIP;
               OVF_CNT <= sat_inc(OVF_CNT);
            end
         end else if (DVALID_IN) begin
            case (wstate)
               W_FILL: begin
                  if (wr_idx == IW'(1)) begin
                     tei    <= DATA_IN[7];
                     pid_hi <= DATA_IN[4:0];
                  end
                  if (wr_idx == IW'(2))
                     pid_lo <= DATA_IN;
                  if (commit) begin
                     wstate <= W_IDLE;
                     if (tei) begin
                        DROP_CNT <= sat_inc(DROP_CNT);
                     end else if (keep_pkt) begin
                        bank_full[wr_ptr] <= 1'b1;
                        bank_pid[wr_ptr]  <= cur_pid;
                        wr_ptr            <= ~wr_ptr;
                     end
                  end else begin
                     wr_idx <= wr_idx + IW'(1);
                  end
               end
               W_SKIP: begin
                  if (wr_idx == LAST_IDX)
                     wstate <= W_IDLE;
                  else
                     wr_idx <= wr_idx + IW'(1);
               end
               default: ;
            endcase
         end
      end
   end

   // ram_q always holds the byte after DATA_OUT, so a transfer advances both stages together
   always_ff @(posedge DCLK or negedge RST) begin
      if (!RST) begin
         rstate     <= R_IDLE;
         rd_ptr     <= 1'b0;
         fetch_idx  <= '0;
         out_idx    <= '0;
         DATA_OUT   <= '0;
         DVALID_OUT <= 1'b0;
         PSYNC_OUT  <= 1'b0;
         PKT_PID    <= '0;
      end else begin
         case (rstate)
            R_IDLE: begin
               if (bank_full[rd_ptr]) begin
                  fetch_idx <= IW'(1);
                  rstate    <= R_SEND;
               end
            end
            R_SEND: begin
               if (!DVALID_OUT) begin
                  DATA_OUT   <= ram_q;
                  DVALID_OUT <= 1'b1;
                  PSYNC_OUT  <= 1'b1;
                  PKT_PID    <= bank_pid[rd_ptr];
                  out_idx    <= '0;
                  fetch_idx  <= fetch_idx + IW'(1);
               end else if (OUT_READY) begin
                  if (out_idx == LAST_IDX) begin
                     DVALID_OUT <= 1'b0;
                     PSYNC_OUT  <= 1'b0;
                     rd_ptr     <= ~rd_ptr;
                     rstate     <= R_IDLE;
                  end else begin
                     DATA_OUT  <= ram_q;
                     PSYNC_OUT <= 1'b0;
                     out_idx   <= out_idx + IW'(1);
                     if (fetch_idx < PKT_LEN_I)
                        fetch_idx <= fetch_idx + IW'(1);
                  end
               end
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ts_pid_filter.sv
// Directed bench for ts_pid_filter: packets are generated from (pid, seed) and the
// captured output stream is compared against the same byte generator.
module tb_ts_pid_filter;

   localparam int PL = 188;

   logic        DCLK = 1'b0;
   logic        RST = 1'b0;
   logic [7:0]  DATA_IN = '0;
   logic        DVALID_IN = 1'b0;
   logic        PSYNC_IN = 1'b0;
   logic        SYNC_FOUND_IN = 1'b1;
   logic [12:0] PID_VALUE = '0;
   logic        PID_FILTER_EN = 1'b0;
   logic        OUT_READY = 1'b0;
   logic [7:0]  DATA_OUT;
   logic        DVALID_OUT;
   logic        PSYNC_OUT;
   logic [12:0] PKT_PID;
   logic [15:0] DROP_CNT;
   logic [15:0] OVF_CNT;

   ts_pid_filter #(.PKT_LEN(PL), .DROP_NULL(1'b1), .CNT_W(16)) dut (
      .DCLK(DCLK), .RST(RST), .DATA_IN(DATA_IN), .DVALID_IN(DVALID_IN),
      .PSYNC_IN(PSYNC_IN), .SYNC_FOUND_IN(SYNC_FOUND_IN), .PID_VALUE(PID_VALUE),
      .PID_FILTER_EN(PID_FILTER_EN), .OUT_READY(OUT_READY), .DATA_OUT(DATA_OUT),
      .DVALID_OUT(DVALID_OUT), .PSYNC_OUT(PSYNC_OUT), .PKT_PID(PKT_PID),
      .DROP_CNT(DROP_CNT), .OVF_CNT(OVF_CNT)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int first_cyc = -1;
   int last_cyc = 0;

   logic [7:0]  cap_data [$];
   logic        cap_psync [$];
   logic [12:0] cap_pid [$];
   bit          hold_pending = 1'b0;
   logic [7:0]  h_data;
   logic        h_psync;
   logic [12:0] h_pid;

   always #5 DCLK = ~DCLK;
   always @(posedge DCLK) cyc++;

   // Output monitor on the falling edge: captures transfers and checks stall hold
   always @(negedge DCLK) begin
      if (!RST) begin
         hold_pending = 1'b0;
      end else begin
         if (hold_pending) begin
            checks++;
            if (DVALID_OUT !== 1'b1 || DATA_OUT !== h_data || PSYNC_OUT !== h_psync || PKT_PID !== h_pid) begin
               errors++;
               $display("FAIL stall_hold got v=%b d=%h s=%b p=%h want v=1 d=%h s=%b p=%h",
                        DVALID_OUT, DATA_OUT, PSYNC_OUT, PKT_PID, h_data, h_psync, h_pid);
            end
         end
         if (DVALID_OUT && OUT_READY) begin
            cap_data.push_back(DATA_OUT);
            cap_psync.push_back(PSYNC_OUT);
            cap_pid.push_back(PKT_PID);
         end
         if (DVALID_OUT && PSYNC_OUT && first_cyc < 0)
            first_cyc = cyc;
         hold_pending = DVALID_OUT && !OUT_READY;
         h_data  = DATA_OUT;
         h_psync = PSYNC_OUT;
         h_pid   = PKT_PID;
      end
   end

   function automatic logic [7:0] pkt_byte(input logic [12:0] pid, input logic tei,
                                            input logic [7:0] seed, input int i);
      logic [7:0] ib;
      ib = 8'(i);
      if (i == 0) return 8'h47;
      if (i == 1) return {tei, 2'b00, pid[12:8]};
      if (i == 2) return pid[7:0];
      return seed + ib * 8'd7;
   endfunction

   // Number of wrong bytes/flags in captured packet p versus the generator
   function automatic int pkt_errs(input int p, input logic [12:0] pid, input logic [7:0] seed);
      int e = 0;
      for (int i = 0; i < PL; i++) begin
         int idx = p * PL + i;
         if (idx >= cap_data.size()) begin
            e++;
         end else begin
            if (cap_data[idx] !== pkt_byte(pid, 1'b0, seed, i)) e++;
            if (cap_psync[idx] !== (i == 0)) e++;
            if (cap_pid[idx] !== pid) e++;
         end
      end
      return e;
   endfunction

   task automatic drive_byte(input logic [7:0] d, input logic ps);
      @(posedge DCLK); #1;
      DATA_IN = d; DVALID_IN = 1'b1; PSYNC_IN = ps;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge DCLK); #1;
         DVALID_IN = 1'b0; PSYNC_IN = 1'b0;
      end
   endtask

   task automatic send_pkt(input logic [12:0] pid, input logic tei, input logic [7:0] seed, input int n);
      for (int i = 0; i < n; i++)
         drive_byte(pkt_byte(pid, tei, seed, i), i == 0);
      last_cyc = cyc;
   endtask

   task automatic wait_bytes(input int n, input int budget);
      for (int t = 0; t < budget && cap_data.size() < n; t++) begin
         @(posedge DCLK); #1;
      end
   endtask

   task automatic clear_cap();
      cap_data.delete(); cap_psync.delete(); cap_pid.delete();
      first_cyc = -1;
   endtask

   task automatic test_reset();
      RST = 1'b0;
      repeat (3) @(posedge DCLK);
      #1;
      checks++; if (DVALID_OUT !== 1'b0) begin errors++; $display("FAIL reset_dvalid got %b want 0", DVALID_OUT); end
      checks++; if (PSYNC_OUT !== 1'b0) begin errors++; $display("FAIL reset_psync got %b want 0", PSYNC_OUT); end
      checks++; if (DATA_OUT !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", DATA_OUT); end
      checks++; if (PKT_PID !== 13'h0) begin errors++; $display("FAIL reset_pid got %h want 0", PKT_PID); end
      checks++; if (DROP_CNT !== 16'd0 || OVF_CNT !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", DROP_CNT, OVF_CNT); end
      @(posedge DCLK); #1;
      RST = 1'b1;
      idle(3);
   endtask

   task automatic test_back_to_back();
      int lat_ref;
      int e;
      clear_cap();
      OUT_READY = 1'b1; PID_FILTER_EN = 1'b0;
      send_pkt(13'h0100, 1'b0, 8'd1, PL);
      lat_ref = last_cyc;
      idle(4);
      for (int s = 2; s <= 5; s++) begin
         send_pkt(13'h0100, 1'b0, 8'(s), PL);
         idle(4);
      end
      wait_bytes(5 * PL, 3000);
      idle(20);
      checks++; if (cap_data.size() !== 5 * PL) begin errors++; $display("FAIL b2b_count got %0d want %0d", cap_data.size(), 5 * PL); end
      checks++; if (first_cyc !== lat_ref + 3) begin errors++; $display("FAIL b2b_latency got cycle %0d want %0d", first_cyc, lat_ref + 3); end
      for (int p = 0; p < 5; p++) begin
         e = pkt_errs(p, 13'h0100, 8'(p + 1));
         checks++; if (e !== 0) begin errors++; $display("FAIL b2b_pkt%0d got %0d bad bytes want 0", p, e); end
      end
      checks++; if (DROP_CNT !== 16'd0 || OVF_CNT !== 16'd0) begin errors++; $display("FAIL b2b_cnt got %0d/%0d want 0/0", DROP_CNT, OVF_CNT); end
   endtask

   task automatic test_pid_filter();
      int e;
      clear_cap();
      PID_VALUE = 13'h0200; PID_FILTER_EN = 1'b1;
      send_pkt(13'h0100, 1'b0, 8'd10, PL); idle(4);
      send_pkt(13'h0200, 1'b0, 8'd11, PL); idle(4);
      send_pkt(13'h1FFF, 1'b0, 8'd12, PL); idle(4);
      send_pkt(13'h0200, 1'b0, 8'd13, PL); idle(4);
      wait_bytes(2 * PL, 2000);
      idle(20);
      checks++; if (cap_data.size() !== 2 * PL) begin errors++; $display("FAIL filt_count got %0d want %0d", cap_data.size(), 2 * PL); end
      e = pkt_errs(0, 13'h0200, 8'd11);
      checks++; if (e !== 0) begin errors++; $display("FAIL filt_pkt0 got %0d bad bytes want 0", e); end
      e = pkt_errs(1, 13'h0200, 8'd13);
      checks++; if (e !== 0) begin errors++; $display("FAIL filt_pkt1 got %0d bad bytes want 0", e); end
      checks++; if (DROP_CNT !== 16'd0 || OVF_CNT !== 16'd0) begin errors++; $display("FAIL filt_cnt got %0d/%0d want 0/0", DROP_CNT, OVF_CNT); end

      clear_cap();
      PID_FILTER_EN = 1'b0;
      send_pkt(13'h1FFF, 1'b0, 8'd14, PL); idle(4);
      send_pkt(13'h0100, 1'b0, 8'd15, PL); idle(4);
      send_pkt(13'h1FFF, 1'b0, 8'd16, PL); idle(4);
      send_pkt(13'h0200, 1'b0, 8'd17, PL); idle(4);
      wait_bytes(2 * PL, 2000);
      idle(20);
      checks++; if (cap_data.size() !== 2 * PL) begin errors++; $display("FAIL null_count got %0d want %0d", cap_data.size(), 2 * PL); end
      e = pkt_errs(0, 13'h0100, 8'd15);
      checks++; if (e !== 0) begin errors++; $display("FAIL null_pkt0 got %0d bad bytes want 0", e); end
      e = pkt_errs(1, 13'h0200, 8'd17);
      checks++; if (e !== 0) begin errors++; $display("FAIL null_pkt1 got %0d bad bytes want 0", e); end
   endtask

   task automatic test_tei();
      int e;
      clear_cap();
      send_pkt(13'h0100, 1'b1, 8'd20, PL); idle(4);
      send_pkt(13'h0100, 1'b0, 8'd21, PL); idle(4);
      wait_bytes(PL, 1000);
      idle(20);
      checks++; if (cap_data.size() !== PL) begin errors++; $display("FAIL tei_count got %0d want %0d", cap_data.size(), PL); end
      e = pkt_errs(0, 13'h0100, 8'd21);
      checks++; if (e !== 0) begin errors++; $display("FAIL tei_pkt got %0d bad bytes want 0", e); end
      checks++; if (DROP_CNT !== 16'd1) begin errors++; $display("FAIL tei_drop got %0d want 1", DROP_CNT); end
   endtask

   task automatic test_short();
      int e;
      clear_cap();
      send_pkt(13'h0100, 1'b0, 8'd30, 100);
      send_pkt(13'h0100, 1'b0, 8'd31, PL); idle(4);
      wait_bytes(PL, 1000);
      idle(20);
      checks++; if (cap_data.size() !== PL) begin errors++; $display("FAIL short_count got %0d want %0d", cap_data.size(), PL); end
      e = pkt_errs(0, 13'h0100, 8'd31);
      checks++; if (e !== 0) begin errors++; $display("FAIL short_pkt got %0d bad bytes want 0", e); end
      checks++; if (DROP_CNT !== 16'd2) begin errors++; $display("FAIL short_drop got %0d want 2", DROP_CNT); end

      clear_cap();
      send_pkt(13'h0100, 1'b0, 8'd32, 50);
      @(posedge DCLK); #1;
      DATA_IN = 8'h55; DVALID_IN = 1'b1; PSYNC_IN = 1'b0; SYNC_FOUND_IN = 1'b0;
      idle(4);
      SYNC_FOUND_IN = 1'b1;
      idle(250);
      checks++; if (cap_data.size() !== 0) begin errors++; $display("FAIL lock_count got %0d want 0", cap_data.size()); end
      checks++; if (DROP_CNT !== 16'd3) begin errors++; $display("FAIL lock_drop got %0d want 3", DROP_CNT); end
   endtask

   task automatic test_overflow();
      int e;
      clear_cap();
      OUT_READY = 1'b0;
      send_pkt(13'h0100, 1'b0, 8'd40, PL); idle(4);
      send_pkt(13'h0100, 1'b0, 8'd41, PL); idle(4);
      send_pkt(13'h0100, 1'b0, 8'd42, PL); idle(10);
      checks++; if (OVF_CNT !== 16'd1) begin errors++; $display("FAIL ovf_cnt got %0d want 1", OVF_CNT); end
      checks++; if (cap_data.size() !== 0) begin errors++; $display("FAIL ovf_stalled got %0d bytes want 0", cap_data.size()); end
      checks++; if (DVALID_OUT !== 1'b1 || PSYNC_OUT !== 1'b1 || DATA_OUT !== 8'h47) begin
         errors++; $display("FAIL ovf_present got v=%b s=%b d=%h want v=1 s=1 d=47", DVALID_OUT, PSYNC_OUT, DATA_OUT);
      end
      OUT_READY = 1'b1;
      wait_bytes(2 * PL, 1000);
      idle(20);
      checks++; if (cap_data.size() !== 2 * PL) begin errors++; $display("FAIL ovf_count got %0d want %0d", cap_data.size(), 2 * PL); end
      e = pkt_errs(0, 13'h0100, 8'd40);
      checks++; if (e !== 0) begin errors++; $display("FAIL ovf_pkt0 got %0d bad bytes want 0", e); end
      e = pkt_errs(1, 13'h0100, 8'd41);
      checks++; if (e !== 0) begin errors++; $display("FAIL ovf_pkt1 got %0d bad bytes want 0", e); end
   endtask

   task automatic test_random_ready();
      int e;
      clear_cap();
      fork
         begin
            for (int s = 50; s <= 52; s++) begin
               send_pkt(13'h0100, 1'b0, 8'(s), PL);
               idle(200);
            end
         end
         begin
            repeat (1300) begin
               @(posedge DCLK); #1;
               OUT_READY = ($urandom_range(0, 3) != 0);
            end
         end
      join
      OUT_READY = 1'b1;
      wait_bytes(3 * PL, 1500);
      idle(20);
      checks++; if (cap_data.size() !== 3 * PL) begin errors++; $display("FAIL rdy_count got %0d want %0d", cap_data.size(), 3 * PL); end
      for (int p = 0; p < 3; p++) begin
         e = pkt_errs(p, 13'h0100, 8'(50 + p));
         checks++; if (e !== 0) begin errors++; $display("FAIL rdy_pkt%0d got %0d bad bytes want 0", p, e); end
      end
      checks++; if (OVF_CNT !== 16'd1) begin errors++; $display("FAIL rdy_ovf got %0d want 1", OVF_CNT); end
   endtask

   task automatic test_reset_mid();
      int e;
      clear_cap();
      OUT_READY = 1'b1;
      send_pkt(13'h0100, 1'b0, 8'd60, PL); idle(4);
      wait_bytes(20, 400);
      #2;
      RST = 1'b0;
      #1;
      checks++; if (DVALID_OUT !== 1'b0 || PSYNC_OUT !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got v=%b s=%b want 0 0", DVALID_OUT, PSYNC_OUT); end
      checks++; if (DATA_OUT !== 8'h00 || PKT_PID !== 13'h0) begin errors++; $display("FAIL mid_rst_data got d=%h p=%h want 00 0", DATA_OUT, PKT_PID); end
      checks++; if (DROP_CNT !== 16'd0 || OVF_CNT !== 16'd0) begin errors++; $display("FAIL mid_rst_cnt got %0d/%0d want 0/0", DROP_CNT, OVF_CNT); end
      @(posedge DCLK); #1;
      RST = 1'b1;
      clear_cap();
      idle(2);
      send_pkt(13'h0300, 1'b0, 8'd61, PL); idle(4);
      wait_bytes(PL, 1000);
      idle(20);
      checks++; if (cap_data.size() !== PL) begin errors++; $display("FAIL mid_rst_count got %0d want %0d", cap_data.size(), PL); end
      e = pkt_errs(0, 13'h0300, 8'd61);
      checks++; if (e !== 0) begin errors++; $display("FAIL mid_rst_pkt got %0d bad bytes want 0", e); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_back_to_back();
      test_pid_filter();
      test_tei();
      test_short();
      test_overflow();
      test_random_ready();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ts_pid_filter.md
Name: ts_pid_filter

Overview:
- Sits directly downstream of the TS sync finder and consumes its aligned byte stream (DATA, DVALID, PSYNC, SYNC_FOUND).
- Captures each 188-byte transport packet into one of two packet banks and checks header integrity and PID.
- Forwards only complete, accepted packets downstream with a valid/ready handshake, so later stages (T2-MI packer) never see partial or filtered-out packets.

Parameters:
- PKT_LEN, 188: bytes per TS packet, including the sync byte.
- DROP_NULL, 1: when 1, packets with PID 0x1FFF are discarded.
- CNT_W, 16: width of the statistics counters.

Ports:
- DCLK  in  1  byte clock, all logic on the rising edge.
- RST  in  1  asynchronous active-low reset.
- DATA_IN  in  8  byte from the sync finder.
- DVALID_IN  in  1  DATA_IN is valid this cycle.
- PSYNC_IN  in  1  sampled only when DVALID_IN=1; high on the packet's first (sync) byte.
- SYNC_FOUND_IN  in  1  sync-lock status from the sync finder.
- PID_VALUE  in  13  PID to pass when filtering is enabled.
- PID_FILTER_EN  in  1  1 = pass only PID_VALUE; 0 = pass all PIDs (subject to the TEI and null rules).
- OUT_READY  in  1  downstream can accept a byte.
- DATA_OUT  out  8  packet byte.
- DVALID_OUT  out  1  DATA_OUT is valid.
- PSYNC_OUT  out  1  high with DVALID_OUT on byte 0 of each output packet.
- PKT_PID  out  13  PID of the packet currently being output.
- DROP_CNT  out  CNT_W  error drops: TEI set, short packet, or lost sync.
- OVF_CNT  out  CNT_W  packets discarded because both banks were occupied.

Behaviour:
- Reset (async, RST=0): all outputs 0, both banks empty, write and read FSMs idle, bank pointers 0.
- Packet buffer: two banks of PKT_LEN bytes each (synchronous-read RAM). Each bank is either FREE or FULL.
- Write FSM, W_IDLE: waits for DVALID_IN & PSYNC_IN & SYNC_FOUND_IN.
  - If the target bank (write pointer) is FREE: store byte 0, go to W_FILL.
  - If it is not FREE: go to W_SKIP and increment OVF_CNT.
- Write FSM, W_FILL: stores each DVALID_IN byte at index 1..PKT_LEN-1.
  - Byte 1 bit 7 is latched as TEI.
  - Bits [12:8] of the PID come from byte 1 [4:0]; bits [7:0] come from byte 2.
- Commit: on the edge that stores index PKT_LEN-1, evaluate the packet:
  - TEI=1: drop and increment DROP_CNT.
  - Otherwise, PID=0x1FFF with DROP_NULL=1: drop silently.
  - Otherwise, PID_FILTER_EN=1 and PID != PID_VALUE (sampled at this edge): drop silently.
  - Otherwise: mark the bank FULL, store its PID, toggle the write pointer.
  - In every case return to W_IDLE. A dropped packet leaves the pointer unchanged, so the bank is reused.
- Abort in W_FILL: increment DROP_CNT, discard the partial packet, pointer unchanged, when either:
  - PSYNC_IN with DVALID_IN arrives before index PKT_LEN-1 (short packet); that byte starts a new packet in the same cycle, following the W_IDLE rules.
  - SYNC_FOUND_IN=0 is sampled; return to W_IDLE.
- W_SKIP: counts PKT_LEN bytes without storing, then returns to W_IDLE. Early PSYNC_IN or loss of SYNC_FOUND_IN ends the skip as above, with no extra count.
- Read FSM, R_IDLE: when the bank at the read pointer is FULL, issue the read of index 0 and go to R_SEND.
- Read FSM, R_SEND:
  - A byte transfers when DVALID_OUT & OUT_READY.
  - DATA_OUT, PSYNC_OUT and PKT_PID are held stable while DVALID_OUT=1 and OUT_READY=0.
  - Bytes are presented in order 0..PKT_LEN-1, back-to-back while OUT_READY=1.
  - After byte PKT_LEN-1 transfers: bank becomes FREE, read pointer toggles, return to R_IDLE.
- Latency: with the read bank FULL and OUT_READY=1, the first output byte (DVALID_OUT=PSYNC_OUT=1) appears exactly 2 DCLK edges after the commit edge.
- Banks are read in commit order. Commit and release of different banks in the same cycle are both honoured. The write FSM may fill one bank while the other is being read.
- Counters saturate at all-ones and never wrap.
- Reset mid-packet: everything clears immediately, no partial output, counters return to 0.
- SYNC_FOUND_IN loss does not interrupt a packet that is already committed or being read out.

Test Plan:
- 5 back-to-back PID 0x0100 packets, PID_FILTER_EN=0, OUT_READY=1 -> 5 packets out, identical bytes, PSYNC_OUT on each byte 0, first byte 2 cycles after the first commit, DROP_CNT=OVF_CNT=0.
- Mixed PIDs 0x0100/0x0200/0x1FFF, filter PID_VALUE=0x0200 -> only 0x0200 packets out, PKT_PID=0x0200, counters 0; with the filter off and DROP_NULL=1 -> 0x1FFF packets absent.
- Packet with byte1=0x81 (TEI) -> not output, DROP_CNT=1, the next good packet is output normally.
- PSYNC_IN at byte 100 of a packet -> partial packet dropped, DROP_CNT=1, the packet starting at that byte is output intact; SYNC_FOUND_IN low at byte 50 -> DROP_CNT increments, nothing output.
- OUT_READY held 0 across 3 incoming packets -> first two buffered, third skipped, OVF_CNT=1; then OUT_READY=1 -> exactly 2 packets out in order. Random OUT_READY toggling -> data held stable while stalled, no byte lost.
- Assert RST mid-readout -> outputs 0 asynchronously; after release the next full packet is output correctly.
